// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the multiplexed 4x4 keypad scanner.
//   kp_state_t : debounce FSM states
//   NONE       : 5-bit frame-result sentinel (no key / multiple keys)
//   keymap()   : (row, col) -> 4-bit key code
// ----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kp_state_t;

   // Bit 4 set marks "no single key"; a valid key code always has bit 4 clear.
   localparam logic [4:0] NONE = 5'h10;

   // Physical key position to hex code; row 3 carries the E/0/F/D keys.
   function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         4'b11_11: code = 4'hD;
         default:  code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_frame_sampler.sv
// ----------------------------------------------------------------------------
// keypad_frame_sampler
// Drives the rotating active-low column strobe, synchronises the rows, samples
// them at the end of each column dwell and reduces a full 4-column frame to a
// single result: the code of the only pressed key, or NONE.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_row[3:0]       keypad rows, active-low, asynchronous
//   o_col[3:0]       one-hot active-low column strobe
//   o_frame_done     one-cycle pulse, o_result valid
//   o_result[4:0]    {1'b0, code} or NONE
// ----------------------------------------------------------------------------
module keypad_frame_sampler
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic       o_frame_done,
   output logic [4:0] o_result
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   logic [3:0]    r_row_s1;
   logic [3:0]    r_row_s2;
   logic [DW-1:0] r_dwell;
   logic [3:0]    r_col;
   logic [1:0]    r_col_idx;
   logic [1:0]    r_hits;       // keys seen so far this frame, saturates at 2
   logic [3:0]    r_code;
   logic          r_frame_done;
   logic [4:0]    r_result;

   logic [3:0]    w_low;
   logic [2:0]    w_col_hits;
   logic [3:0]    w_col_code;
   logic [2:0]    w_sum;
   logic [1:0]    w_total;
   logic [3:0]    w_code;

   // Count low rows in the current column and fold them into the frame tally.
   always_comb begin
      w_low      = ~r_row_s2;
      w_col_hits = 3'd0;
      w_col_code = 4'h0;
      for (int r = 0; r < 4; r++) begin
         if (w_low[r]) begin
            w_col_hits = w_col_hits + 3'd1;
            w_col_code = keymap(2'(r), r_col_idx);
         end else begin
            w_col_hits = w_col_hits;
         end
      end
      w_sum = {1'b0, r_hits} + w_col_hits;
      if (w_sum >= 3'd2) begin
         w_total = 2'd2;
      end else begin
         w_total = w_sum[1:0];
      end
      if (w_col_hits != 3'd0) begin
         w_code = w_col_code;
      end else begin
         w_code = r_code;
      end
   end

   // Row synchroniser, dwell counter, column rotation and frame accumulation.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row_s1     <= 4'hF;
         r_row_s2     <= 4'hF;
         r_dwell      <= '0;
         r_col        <= 4'b1110;
         r_col_idx    <= 2'd0;
         r_hits       <= 2'd0;
         r_code       <= 4'h0;
         r_frame_done <= 1'b0;
         r_result     <= NONE;
      end else begin
         r_row_s1     <= i_row;
         r_row_s2     <= r_row_s1;
         r_frame_done <= 1'b0;
         if (r_dwell == DWELL_LAST) begin
            r_dwell   <= '0;
            r_col     <= {r_col[2:0], r_col[3]};
            r_col_idx <= r_col_idx + 2'd1;
            if (r_col_idx == 2'd3) begin
               r_frame_done <= 1'b1;
               r_result     <= (w_total == 2'd1) ? {1'b0, w_code} : NONE;
               r_hits       <= 2'd0;
               r_code       <= 4'h0;
            end else begin
               r_hits <= w_total;
               r_code <= w_code;
            end
         end else begin
            r_dwell <= r_dwell + DW'(1);
         end
      end
   end

   assign o_col        = r_col;
   assign o_frame_done = r_frame_done;
   assign o_result     = r_result;

endmodule

// File: rtl/mux_keypad_scanner.sv
// ----------------------------------------------------------------------------
// mux_keypad_scanner
// Scans a 4x4 matrix keypad, debounces press and release over whole frames and
// shifts each accepted key code into a 16-bit hex word (newest nibble in [3:0]).
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_row[3:0]       keypad rows, active-low, asynchronous
//   i_clear          synchronous clear of o_hex
//   o_col[3:0]       column strobe, one-hot active-low
//   o_key_valid      one-cycle pulse per accepted key
//   o_key_code[3:0]  last accepted key code
//   o_hex[15:0]      shift register of accepted codes
// ----------------------------------------------------------------------------
module mux_keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_row,
   input  logic        i_clear,
   output logic [3:0]  o_col,
   output logic        o_key_valid,
   output logic [3:0]  o_key_code,
   output logic [15:0] o_hex
);

   localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_DB  = CW'(DEBOUNCE);

   logic          w_frame_done;
   logic [4:0]    w_result;

   kp_state_t     r_state;
   kp_state_t     w_state_n;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_n;
   logic [CW-1:0] w_cnt_inc;
   logic [3:0]    r_cand;
   logic [3:0]    w_cand_n;
   logic          w_accept;
   logic          w_match;

   logic          r_key_valid;
   logic [3:0]    r_key_code;
   logic [15:0]   r_hex;

   keypad_frame_sampler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_sampler (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_row        (i_row),
      .o_col        (o_col),
      .o_frame_done (w_frame_done),
      .o_result     (w_result)
   );

   // Debounce FSM next state; only a frame end can move it.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_cand_n  = r_cand;
      w_accept  = 1'b0;
      w_match   = (w_result == {1'b0, r_cand});
      w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
      if (w_frame_done) begin
         case (r_state)
            IDLE: begin
               if (w_result != NONE) begin
                  w_cand_n = w_result[3:0];
                  if (DEBOUNCE <= 1) begin
                     w_accept  = 1'b1;
                     w_state_n = HELD;
                     w_cnt_n   = '0;
                  end else begin
                     w_state_n = PRESS_DB;
                     w_cnt_n   = CNT_ONE;
                  end
               end else begin
                  w_cnt_n = '0;
               end
            end
            PRESS_DB: begin
               if (w_match) begin
                  if (w_cnt_inc >= CNT_DB) begin
                     w_accept  = 1'b1;
                     w_state_n = HELD;
                     w_cnt_n   = '0;
                  end else begin
                     w_cnt_n = w_cnt_inc;
                  end
               end else begin
                  w_state_n = IDLE;
                  w_cnt_n   = '0;
               end
            end
            HELD: begin
               if (!w_match) begin
                  if (DEBOUNCE <= 1) begin
                     w_state_n = IDLE;
                     w_cnt_n   = '0;
                  end else begin
                     w_state_n = REL_DB;
                     w_cnt_n   = CNT_ONE;
                  end
               end else begin
                  w_state_n = HELD;
               end
            end
            REL_DB: begin
               if (!w_match) begin
                  if (w_cnt_inc >= CNT_DB) begin
                     w_state_n = IDLE;
                     w_cnt_n   = '0;
                  end else begin
                     w_cnt_n = w_cnt_inc;
                  end
               end else begin
                  w_state_n = HELD;
                  w_cnt_n   = '0;
               end
            end
            default: begin
               w_state_n = IDLE;
               w_cnt_n   = '0;
            end
         endcase
      end else begin
         w_state_n = r_state;
      end
   end

   // FSM state, candidate and match counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_cand  <= 4'h0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_cand  <= w_cand_n;
      end
   end

   // Registered outputs; an accept shifts the hex word, clear wins over history.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key_valid <= 1'b0;
         r_key_code  <= 4'h0;
         r_hex       <= 16'h0000;
      end else begin
         r_key_valid <= w_accept;
         if (w_accept) begin
            r_key_code <= w_cand_n;
            r_hex      <= i_clear ? {12'h000, w_cand_n} : {r_hex[11:0], w_cand_n};
         end else if (i_clear) begin
            r_hex <= 16'h0000;
         end else begin
            r_hex <= r_hex;
         end
      end
   end

   assign o_key_valid = r_key_valid;
   assign o_key_code  = r_key_code;
   assign o_hex       = r_hex;

endmodule
